// File: rtl/pwm_ctrl_pkg.sv
// Shared types and helpers for the PWM ramp controller.
package pwm_ctrl_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RAMP = 1'b1
    } state_t;

    localparam int STEP_MAX_W = 32;

    // A zero step would never converge, so it is promoted to one.
    function automatic logic [STEP_MAX_W-1:0] clamp_step(input logic [STEP_MAX_W-1:0] s);
        return (s == '0) ? STEP_MAX_W'(1) : s;
    endfunction

endpackage

// File: rtl/tick_div.sv
// Free-running prescaler: tick every div+1 enabled cycles, restartable via clr.
module tick_div #(
    parameter int DIV_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    input  logic [DIV_W-1:0] div,
    output logic             tick
);

    logic [DIV_W-1:0] count;

    assign tick = en && (count == div);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en) begin
            count <= (count == div) ? '0 : count + 1'b1;
        end
    end

endmodule

// File: rtl/pwm_ramp_ctrl.sv
// Command sequencer owning period/duty of one pwm instance; ramps duty toward
// a target in clamped steps at a programmable tick rate.
module pwm_ramp_ctrl
    import pwm_ctrl_pkg::*;
#(
    parameter int N     = 16,
    parameter int DIV_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [N-1:0]     cmd_target,
    input  logic [N-1:0]     cmd_step,
    input  logic [DIV_W-1:0] cmd_div,
    input  logic [N-1:0]     cmd_period,
    input  logic             abort,
    output logic [N-1:0]     pwm_period,
    output logic [N-1:0]     pwm_duty,
    output logic             busy,
    output logic             done
);

    state_t           state;
    logic [N-1:0]     tgt_r;
    logic [N-1:0]     step_r;
    logic [DIV_W-1:0] div_r;
    logic             accept;
    logic             tick;
    logic             going_up;
    logic [N:0]       diff;

    assign cmd_ready = (state == IDLE);
    assign busy      = (state == RAMP);
    assign accept    = cmd_valid && cmd_ready;
    assign going_up  = (tgt_r > pwm_duty);

    // One extra bit so the comparison against step never wraps.
    always_comb begin
        diff = '0;
        if (going_up) diff = {1'b0, tgt_r} - {1'b0, pwm_duty};
        else          diff = {1'b0, pwm_duty} - {1'b0, tgt_r};
    end

    tick_div #(.DIV_W(DIV_W)) u_tick_div (
        .clk  (clk),
        .rst  (rst),
        .clr  (accept),
        .en   (busy),
        .div  (div_r),
        .tick (tick)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            tgt_r      <= '0;
            step_r     <= '0;
            div_r      <= '0;
            pwm_period <= '0;
            pwm_duty   <= '0;
            done       <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        tgt_r      <= cmd_target;
                        step_r     <= N'(clamp_step(STEP_MAX_W'(cmd_step)));
                        div_r      <= cmd_div;
                        pwm_period <= cmd_period;
                        if (cmd_target == pwm_duty) done  <= 1'b1;
                        else                        state <= RAMP;
                    end
                end
                RAMP: begin
                    // Abort outranks a coincident tick: duty stays put.
                    if (abort) begin
                        state <= IDLE;
                    end else if (tick) begin
                        if (diff <= {1'b0, step_r}) begin
                            pwm_duty <= tgt_r;
                            done     <= 1'b1;
                            state    <= IDLE;
                        end else if (going_up) begin
                            pwm_duty <= pwm_duty + step_r;
                        end else begin
                            pwm_duty <= pwm_duty - step_r;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pwm_ramp_ctrl.sv
// Directed bench for pwm_ramp_ctrl with hand-computed expected values.
module tb_pwm_ramp_ctrl;

    localparam int N     = 16;
    localparam int DIV_W = 16;

    logic             clk = 1'b0;
    logic             rst;
    logic             cmd_valid;
    logic             cmd_ready;
    logic [N-1:0]     cmd_target;
    logic [N-1:0]     cmd_step;
    logic [DIV_W-1:0] cmd_div;
    logic [N-1:0]     cmd_period;
    logic             abort;
    logic [N-1:0]     pwm_period;
    logic [N-1:0]     pwm_duty;
    logic             busy;
    logic             done;

    int n_tests = 0;
    int n_fail  = 0;

    pwm_ramp_ctrl #(.N(N), .DIV_W(DIV_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_target (cmd_target),
        .cmd_step   (cmd_step),
        .cmd_div    (cmd_div),
        .cmd_period (cmd_period),
        .abort      (abort),
        .pwm_period (pwm_period),
        .pwm_duty   (pwm_duty),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Offer a command, hold it through one rising edge, then withdraw it.
    task automatic send(input int tgt, input int step, input int div, input int per);
        cmd_target = N'(tgt);
        cmd_step   = N'(step);
        cmd_div    = DIV_W'(div);
        cmd_period = N'(per);
        cmd_valid  = 1'b1;
        @(posedge clk);
        #1 cmd_valid = 1'b0;
    endtask

    initial begin
        int dn_exp[4];
        rst = 1'b0; cmd_valid = 1'b0; abort = 1'b0;
        cmd_target = '0; cmd_step = '0; cmd_div = '0; cmd_period = '0;

        // Reset state
        #12;
        chk("rst_period", pwm_period, 0);
        chk("rst_duty", pwm_duty, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_ready", cmd_ready, 1);
        @(negedge clk) rst = 1'b1;
        @(negedge clk);

        // Up-ramp 0 -> 100, step 10, div 3
        send(100, 10, 3, 500);
        @(negedge clk);
        chk("up_period", pwm_period, 500);
        chk("up_busy", busy, 1);
        chk("up_ready", cmd_ready, 0);
        for (int i = 1; i <= 10; i++) begin
            repeat (3) @(negedge clk);
            chk("up_hold", pwm_duty, 32'(10 * (i - 1)));
            @(negedge clk);
            chk("up_duty", pwm_duty, 32'(10 * i));
            chk("up_done", done, (i == 10) ? 1 : 0);
        end
        chk("up_end_busy", busy, 0);
        @(negedge clk);
        chk("up_done_once", done, 0);

        // Clamped down-ramp 100 -> 5, step 30, div 0
        dn_exp = '{70, 40, 10, 5};
        send(5, 30, 0, 600);
        @(negedge clk);
        chk("dn_start", pwm_duty, 100);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("dn_duty", pwm_duty, 32'(dn_exp[i]));
            chk("dn_done", done, (i == 3) ? 1 : 0);
        end

        // Target equals current duty
        send(5, 7, 2, 700);
        @(negedge clk);
        chk("eq_done", done, 1);
        chk("eq_busy", busy, 0);
        chk("eq_ready", cmd_ready, 1);
        chk("eq_period", pwm_period, 700);
        @(negedge clk);
        chk("eq_done_clr", done, 0);

        // Step 0 behaves as step 1
        send(8, 0, 0, 700);
        @(negedge clk);
        chk("s0_busy", busy, 1);
        for (int i = 6; i <= 8; i++) begin
            @(negedge clk);
            chk("s0_duty", pwm_duty, 32'(i));
            chk("s0_done", done, (i == 8) ? 1 : 0);
        end

        // Abort coincident with a tick
        send(40, 4, 1, 800);
        @(negedge clk);
        chk("ab_d0", pwm_duty, 8);
        @(negedge clk);
        chk("ab_d1", pwm_duty, 8);
        @(negedge clk);
        chk("ab_d2", pwm_duty, 12);
        @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("ab_duty", pwm_duty, 12);
        chk("ab_busy", busy, 0);
        chk("ab_done", done, 0);
        chk("ab_ready", cmd_ready, 1);
        send(20, 8, 0, 900);
        @(negedge clk);
        chk("ab_next_busy", busy, 1);
        chk("ab_next_period", pwm_period, 900);
        @(negedge clk);
        chk("ab_next_duty", pwm_duty, 20);
        chk("ab_next_done", done, 1);

        // Back-to-back with cmd_valid held; second command parked on the bus
        cmd_target = 30; cmd_step = 5; cmd_div = 0; cmd_period = 200;
        cmd_valid = 1'b1;
        @(posedge clk);
        #1;
        cmd_target = 10; cmd_step = 10; cmd_div = 0; cmd_period = 300;
        @(negedge clk);
        chk("bb_period1", pwm_period, 200);
        chk("bb_busy1", busy, 1);
        @(negedge clk);
        chk("bb_d1", pwm_duty, 25);
        @(negedge clk);
        chk("bb_d2", pwm_duty, 30);
        chk("bb_done1", done, 1);
        chk("bb_ready1", cmd_ready, 1);
        chk("bb_period_hold", pwm_period, 200);
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        @(negedge clk);
        chk("bb_period2", pwm_period, 300);
        chk("bb_busy2", busy, 1);
        chk("bb_d3", pwm_duty, 30);
        @(negedge clk);
        chk("bb_d4", pwm_duty, 20);
        @(negedge clk);
        chk("bb_d5", pwm_duty, 10);
        chk("bb_done2", done, 1);

        // Async reset mid-ramp
        send(1000, 1, 0, 77);
        repeat (6) @(negedge clk);
        chk("ar_pre_duty", pwm_duty, 15);
        #2 rst = 1'b0;
        #1;
        chk("ar_period", pwm_period, 0);
        chk("ar_duty", pwm_duty, 0);
        chk("ar_busy", busy, 0);
        chk("ar_done", done, 0);
        chk("ar_ready", cmd_ready, 1);
        @(negedge clk) rst = 1'b1;
        @(negedge clk);
        chk("ar_post_ready", cmd_ready, 1);
        chk("ar_post_duty", pwm_duty, 0);
        chk("ar_post_busy", busy, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
